// File: rtl/prn_sync_checker_if.sv
// Bit-stream and status bundle between a recovered-data source and the PRBS10 checker.
// The master drives data and error-clear; the checker (slave) reports lock and BER status.
interface prn_sync_checker_if;
    logic        din;
    logic        clr_err;
    logic        lock;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [1:0]  state;

    modport master (
        output din,
        output clr_err,
        input  lock,
        input  err_pulse,
        input  err_cnt,
        input  state
    );

    modport slave (
        input  din,
        input  clr_err,
        output lock,
        output err_pulse,
        output err_cnt,
        output state
    );
endinterface

// File: rtl/prn_sync_checker.sv
// Self-synchronising PRBS10 (x^10+x^7+1) checker: acquires lock on the recovered bit stream,
// counts bit errors while locked and drops lock when a window's error density is too high.
module prn_sync_checker #(
    parameter int unsigned LOCK_CNT = 32,
    parameter int unsigned WIN_LEN  = 256,
    parameter int unsigned ERR_THR  = 8
) (
    input logic              clk,
    input logic              rst,
    prn_sync_checker_if.slave bus
);

    localparam int unsigned VcntW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int unsigned WcntW = $clog2(WIN_LEN);

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [9:0]         s_q, s_d;
    logic [3:0]         fill_q, fill_d;
    logic [VcntW-1:0]   vcnt_q, vcnt_d;
    logic [WcntW-1:0]   wcnt_q, wcnt_d;
    logic [WcntW-1:0]   werr_q, werr_d;
    logic               err_pulse_q, err_pulse_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic               pred;
    logic               err;
    logic [WcntW:0]     wsum;

    assign pred = s_q[9] ^ s_q[6];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        fill_d  = fill_q;
        vcnt_d  = vcnt_q;
        wcnt_d  = wcnt_q;
        werr_d  = werr_q;
        err     = 1'b0;
        wsum    = '0;

        case (state_q)
            StSearch: begin
                s_d    = {s_q[8:0], bus.din};
                vcnt_d = '0;
                if (fill_q == 4'd9) begin
                    fill_d = '0;
                    // An all-zero register is the LFSR lockup state; refill instead.
                    if (s_d != 10'd0) begin
                        state_d = StVerify;
                    end
                end else begin
                    fill_d = fill_q + 4'd1;
                end
            end
            StVerify: begin
                if (bus.din == pred) begin
                    s_d = {s_q[8:0], bus.din};
                    if (vcnt_q == VcntW'(LOCK_CNT - 1)) begin
                        state_d = StLocked;
                        vcnt_d  = '0;
                        wcnt_d  = '0;
                        werr_d  = '0;
                    end else begin
                        vcnt_d = vcnt_q + VcntW'(1);
                    end
                end else begin
                    state_d = StSearch;
                    fill_d  = '0;
                    vcnt_d  = '0;
                end
            end
            StLocked: begin
                // Free-running reference: received errors never enter the register.
                s_d  = {s_q[8:0], pred};
                err  = bus.din ^ pred;
                wsum = {1'b0, werr_q} + {{WcntW{1'b0}}, err};
                if (wcnt_q == WcntW'(WIN_LEN - 1)) begin
                    wcnt_d = '0;
                    werr_d = '0;
                    if (32'(wsum) > ERR_THR) begin
                        state_d = StSearch;
                        fill_d  = '0;
                    end
                end else begin
                    wcnt_d = wcnt_q + WcntW'(1);
                    werr_d = werr_q + WcntW'(err);
                end
            end
            default: begin
                state_d = StSearch;
                fill_d  = '0;
                vcnt_d  = '0;
            end
        endcase

        err_pulse_d = err;
        if (bus.clr_err) begin
            err_cnt_d = '0;
        end else if (err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StSearch;
            s_q         <= '0;
            fill_q      <= '0;
            vcnt_q      <= '0;
            wcnt_q      <= '0;
            werr_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            vcnt_q      <= vcnt_d;
            wcnt_q      <= wcnt_d;
            werr_q      <= werr_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.lock      = (state_q == StLocked);
    assign bus.state     = state_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prn_sync_checker.sv
// Scoreboarded bench for prn_sync_checker: a bit-history reference model predicts every
// cycle's outputs, a monitor compares them, and directed checks pin the key latencies.
module tb_prn_sync_checker;

    localparam int unsigned LOCK_CNT = 32;
    localparam int unsigned WIN_LEN  = 256;
    localparam int unsigned ERR_THR  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prn_sync_checker_if bus();

    prn_sync_checker #(
        .LOCK_CNT (LOCK_CNT),
        .WIN_LEN  (WIN_LEN),
        .ERR_THR  (ERR_THR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  state;
        logic        lock;
        logic        err_pulse;
        logic [15:0] err_cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: last ten accepted bits, oldest first, plus mode and counts.
    int m_mode;
    bit m_hist[$];
    int m_fill, m_match, m_wpos, m_werr, m_ecnt;
    bit m_epulse;

    // Clean PRBS10 source: b[n] = b[n-10] ^ b[n-7], seeded with ten ones.
    bit g[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_hist = {};
        repeat (10) m_hist.push_back(1'b0);
        m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_ecnt = 0;
        m_epulse = 1'b0;
    endtask

    task automatic model_step(input bit b, input bit clr);
        bit pred = m_hist[0] ^ m_hist[3];
        bit e = 1'b0;
        bit zero;
        case (m_mode)
            0: begin
                m_hist.push_back(b);
                void'(m_hist.pop_front());
                m_fill++;
                if (m_fill == 10) begin
                    m_fill = 0;
                    zero = 1'b1;
                    foreach (m_hist[i]) if (m_hist[i]) zero = 1'b0;
                    if (!zero) begin
                        m_mode = 1;
                        m_match = 0;
                    end
                end
            end
            1: begin
                if (b == pred) begin
                    m_hist.push_back(b);
                    void'(m_hist.pop_front());
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_mode = 2; m_wpos = 0; m_werr = 0;
                    end
                end else begin
                    m_mode = 0; m_fill = 0;
                end
            end
            default: begin
                e = (b != pred);
                m_hist.push_back(pred);
                void'(m_hist.pop_front());
                m_wpos++;
                m_werr += int'(e);
                if (m_wpos == WIN_LEN) begin
                    if (m_werr > ERR_THR) begin
                        m_mode = 0; m_fill = 0;
                    end
                    m_wpos = 0; m_werr = 0;
                end
            end
        endcase
        if (clr) m_ecnt = 0;
        else if (e && m_ecnt < 65535) m_ecnt++;
        m_epulse = e;
    endtask

    task automatic step(input bit b, input bit clr, input bit r);
        exp_t x;
        @(negedge clk);
        bus.din = b;
        bus.clr_err = clr;
        rst = r;
        if (!r) model_reset();
        else model_step(b, clr);
        x.state     = 2'(m_mode);
        x.lock      = (m_mode == 2);
        x.err_pulse = m_epulse;
        x.err_cnt   = 16'(m_ecnt);
        exp_q.push_back(x);
    endtask

    task automatic next_prbs(output bit b);
        b = g[0] ^ g[3];
        g.push_back(b);
        void'(g.pop_front());
    endtask

    task automatic clean(input int n);
        bit b;
        repeat (n) begin
            next_prbs(b);
            step(b, 1'b0, 1'b1);
        end
    endtask

    task automatic inv(input int n);
        bit b;
        repeat (n) begin
            next_prbs(b);
            step(~b, 1'b0, 1'b1);
        end
    endtask

    task automatic do_reset();
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are presented every cycle, compare one entry per edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("state",     32'(bus.state),     32'(mon_e.state));
            chk("lock",      32'(bus.lock),      32'(mon_e.lock));
            chk("err_pulse", 32'(bus.err_pulse), 32'(mon_e.err_pulse));
            chk("err_cnt",   32'(bus.err_cnt),   32'(mon_e.err_cnt));
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b;
        int nerr;
        bus.din = 1'b0;
        bus.clr_err = 1'b0;
        model_reset();
        repeat (10) g.push_back(1'b1);

        // Reset with random data, then one cycle after release.
        repeat (3) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        settle();
        chk("post_reset_state", 32'(bus.state), 32'd0);

        // Clean acquisition: lock rises after the 42nd sampled bit.
        do_reset();
        clean(41);
        settle();
        chk("lock_edge41", 32'(bus.lock), 32'd0);
        clean(1);
        settle();
        chk("lock_edge42", 32'(bus.lock), 32'd1);
        clean(2000);
        settle();
        chk("clean_err_cnt", 32'(bus.err_cnt), 32'd0);

        // Single error while locked.
        inv(1);
        settle();
        chk("single_pulse", 32'(bus.err_pulse), 32'd1);
        clean(1);
        settle();
        chk("single_pulse_end", 32'(bus.err_pulse), 32'd0);
        clean(300);
        settle();
        chk("single_err_cnt", 32'(bus.err_cnt), 32'd1);
        chk("single_lock", 32'(bus.lock), 32'd1);

        // Nine errors in one window: lock drops on the window's last bit.
        do_reset();
        clean(42);
        nerr = 0;
        for (int i = 0; i < int'(WIN_LEN) - 1; i++) begin
            if ((i % 20) == 5 && nerr < 9) begin
                inv(1);
                nerr++;
            end else begin
                clean(1);
            end
        end
        settle();
        chk("win_lock_before_end", 32'(bus.lock), 32'd1);
        clean(1);
        settle();
        chk("win_lock_lost", 32'(bus.lock), 32'd0);
        chk("win_state", 32'(bus.state), 32'd0);
        chk("win_err_cnt", 32'(bus.err_cnt), 32'd9);
        clean(41);
        settle();
        chk("relock_41", 32'(bus.lock), 32'd0);
        clean(1);
        settle();
        chk("relock_42", 32'(bus.lock), 32'd1);
        chk("relock_err_cnt", 32'(bus.err_cnt), 32'd9);

        // Mismatch on the 20th verify bit restarts acquisition.
        do_reset();
        clean(29);
        inv(1);
        settle();
        chk("verify_abort_state", 32'(bus.state), 32'd0);
        clean(41);
        settle();
        chk("verify_restart_41", 32'(bus.lock), 32'd0);
        clean(1);
        settle();
        chk("verify_restart_42", 32'(bus.lock), 32'd1);

        // All-zero input never leaves SEARCH.
        do_reset();
        repeat (300) step(1'b0, 1'b0, 1'b1);
        settle();
        chk("zero_state", 32'(bus.state), 32'd0);
        chk("zero_lock", 32'(bus.lock), 32'd0);

        // Randomised errors and clears while tracking.
        do_reset();
        clean(42);
        repeat (1500) begin
            next_prbs(b);
            if ($urandom_range(0, 39) == 0) b = ~b;
            step(b, 1'($urandom_range(0, 299) == 0), 1'b1);
        end

        // Drive err_cnt into saturation with repeated fully-errored windows.
        do_reset();
        repeat (257) begin
            clean(42);
            inv(int'(WIN_LEN));
        end
        settle();
        chk("sat_err_cnt", 32'(bus.err_cnt), 32'hFFFF);
        clean(42);
        inv(10);
        next_prbs(b);
        step(~b, 1'b1, 1'b1);
        settle();
        chk("clr_on_error", 32'(bus.err_cnt), 32'd0);
        inv(5);
        settle();
        chk("lock_before_rst", 32'(bus.lock), 32'd1);
        next_prbs(b);
        step(b, 1'b0, 1'b0);
        settle();
        chk("rst_while_locked", 32'(bus.lock), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);

        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) settle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
